// File: rtl/fir_quant_pkg.sv
// ============================================================================
// Module : fir_quant_pkg
// Brief  : Shared widths, saturation bounds and rounding helpers for the FIR
//          output quantiser.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fir_quant_pkg;

    localparam int ACC_WIDTH = 64;
    localparam int OUT_WIDTH = 16;

    // Wide enough for any accumulator width this block is expected to see.
    localparam int WIDE = 128;

    typedef logic signed [OUT_WIDTH-1:0] sample_t;

    localparam sample_t SAT_MAX = sample_t'({1'b0, {(OUT_WIDTH-1){1'b1}}});
    localparam sample_t SAT_MIN = sample_t'({1'b1, {(OUT_WIDTH-1){1'b0}}});

    function automatic logic signed [WIDE-1:0] sat_max_of(input int width);
        return (128'sd1 <<< (width - 1)) - 128'sd1;
    endfunction

    function automatic logic signed [WIDE-1:0] sat_min_of(input int width);
        return -(128'sd1 <<< (width - 1));
    endfunction

    // Half an output LSB, added before the shift for round-half-up.
    function automatic logic signed [WIDE-1:0] round_shift(input int shift);
        return (shift > 0) ? (128'sd1 <<< (shift - 1)) : 128'sd0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// ============================================================================
// Module : sync_fifo_fwft
// Brief  : Synchronous first-word-fall-through FIFO; head word visible on
//          o_data whenever non-empty, zero when empty.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_level == '0);
    assign o_full    = (r_level == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + (AW+1)'(1);
                2'b01:   r_level <= r_level - (AW+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule

`default_nettype wire

// File: rtl/fir_out_quantizer.sv
// ============================================================================
// Module : fir_out_quantizer
// Brief  : Decimate, round-half-up, shift and saturate the FIR accumulator
//          stream into a FWFT output FIFO with sticky overflow.
//          Optional macro FIR_QUANT_SAT_CNT_EN enables the saturation counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fir_out_quantizer #(
    parameter int ACC_WIDTH  = fir_quant_pkg::ACC_WIDTH,
    parameter int OUT_WIDTH  = fir_quant_pkg::OUT_WIDTH,
    parameter int SHIFT      = 31,
    parameter int DECIM      = 1,
    parameter int PHASE      = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ACC_WIDTH-1:0]            in_data,
    input  logic                            in_valid,
    output logic [OUT_WIDTH-1:0]            out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     sat_count
);

    import fir_quant_pkg::*;

    localparam int XW = ACC_WIDTH + 1;
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [XW-1:0] c_HALF    = XW'(round_shift(SHIFT));
    localparam logic signed [XW-1:0] c_SAT_MAX = XW'(sat_max_of(OUT_WIDTH));
    localparam logic signed [XW-1:0] c_SAT_MIN = XW'(sat_min_of(OUT_WIDTH));

    logic [PW-1:0]                r_phase;
    logic                         w_keep;
    logic signed [XW-1:0]         w_rnd;
    logic signed [XW-1:0]         w_shr;
    logic signed [XW-1:0]         r_s1;
    logic                         r_s1_valid;
    logic signed [OUT_WIDTH-1:0]  w_sat;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_empty;
    logic                         r_overflow;

    assign w_keep = in_valid && (r_phase == PW'(PHASE));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= '0;
        end else if (in_valid) begin
            r_phase <= (r_phase == PW'(DECIM - 1)) ? '0 : r_phase + PW'(1);
        end
    end

    // One extra bit of headroom so adding the half LSB can never wrap.
    assign w_rnd = $signed({in_data[ACC_WIDTH-1], in_data}) + c_HALF;
    assign w_shr = w_rnd >>> SHIFT;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
        end
        r_s1 <= w_shr;
    end

    always_comb begin
        if (r_s1 > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[OUT_WIDTH-1:0];
        end else if (r_s1 < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            w_sat = r_s1[OUT_WIDTH-1:0];
        end
    end

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_pop  = out_valid && out_ready;
    assign w_push = r_s1_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (r_s1_valid && w_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo_fwft #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_sat),
        .i_pop   (w_pop),
        .o_data  (out_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    assign out_valid = !w_empty;
    assign overflow  = r_overflow;

`ifdef FIR_QUANT_SAT_CNT_EN
    logic [15:0] r_sat_cnt;
    logic        w_clamped;

    assign w_clamped = (r_s1 > c_SAT_MAX) || (r_s1 < c_SAT_MIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sat_cnt <= '0;
        end else if (w_push && w_clamped && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign sat_count = r_sat_cnt;
`else
    assign sat_count = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fir_out_quantizer.sv
// ============================================================================
// Module : tb_fir_out_quantizer
// Brief  : Self-checking bench: two quantiser instances (DECIM=1 and DECIM=4)
//          against a queue-based behavioural model, plus directed literals.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fir_out_quantizer;

    localparam int AW    = 64;
    localparam int OW    = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int NU    = 2;

`ifdef FIR_QUANT_SAT_CNT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst        [NU];
    logic [AW-1:0] in_data    [NU];
    logic          in_valid   [NU];
    logic          out_ready  [NU];
    logic [OW-1:0] out_data   [NU];
    logic          out_valid  [NU];
    logic          overflow   [NU];
    logic [LW-1:0] fifo_level [NU];
    logic [15:0]   sat_count  [NU];

    fir_out_quantizer #(
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(31),
        .DECIM(1), .PHASE(0), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .reset(rst[0]), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .overflow(overflow[0]), .fifo_level(fifo_level[0]), .sat_count(sat_count[0])
    );

    fir_out_quantizer #(
        .ACC_WIDTH(AW), .OUT_WIDTH(OW), .SHIFT(31),
        .DECIM(4), .PHASE(1), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .reset(rst[1]), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .overflow(overflow[1]), .fifo_level(fifo_level[1]), .sat_count(sat_count[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    function automatic int decim_of(input int u);
        return (u == 0) ? 1 : 4;
    endfunction

    function automatic int phase_of(input int u);
        return (u == 0) ? 0 : 1;
    endfunction

    // Exact value of x / 2^31 rounded half-up, before clamping.
    function automatic logic signed [127:0] q_pre(input logic [AW-1:0] x);
        logic signed [127:0] v;
        v = {{64{x[63]}}, x};
        v = v + (128'sd1 <<< 30);
        return v >>> 31;
    endfunction

    function automatic bit out_of_range(input logic signed [127:0] v);
        return (v > 128'sd32767) || (v < -128'sd32768);
    endfunction

    function automatic int clamp16(input logic signed [127:0] v);
        if (v > 128'sd32767) return 32767;
        if (v < -128'sd32768) return -32768;
        return int'(v);
    endfunction

    function automatic logic [AW-1:0] fx(input longint k, input longint frac);
        longint r;
        r = (k <<< 31) + frac;
        return r;
    endfunction

    task automatic chk(input string name, input int u, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s unit=%0d got=%0d expected=%0d (cycle %0d)", name, u, act, exp, cyc);
        end
    endtask

    // Behavioural model: a queue per instance mirrors the FIFO contents.
    int                  m_q    [NU][$];
    bit                  m_s1v  [NU];
    logic signed [127:0] m_s1   [NU];
    int                  m_cnt  [NU];
    bit                  m_ovf  [NU];
    int                  m_sat  [NU];
    bit                  m_live [NU];
    bit                  m_pop;
    bit                  m_keep;

    int obs   [NU][$];
    int obs_c [NU][$];

    always @(posedge clk) begin
        cyc++;
        for (int u = 0; u < NU; u++) begin
            if (rst[u]) begin
                m_q[u].delete();
                m_s1v[u]  = 1'b0;
                m_cnt[u]  = 0;
                m_ovf[u]  = 1'b0;
                m_sat[u]  = 0;
                m_live[u] = 1'b1;
            end else if (m_live[u]) begin
                m_pop = (m_q[u].size() > 0) && out_ready[u];
                if (m_pop) void'(m_q[u].pop_front());
                if (m_s1v[u]) begin
                    if (m_q[u].size() < DEPTH) begin
                        m_q[u].push_back(clamp16(m_s1[u]));
                        if (out_of_range(m_s1[u]) && m_sat[u] < 65535) m_sat[u]++;
                    end else begin
                        m_ovf[u] = 1'b1;
                    end
                end
                m_keep = in_valid[u] && (m_cnt[u] == phase_of(u));
                if (in_valid[u]) m_cnt[u] = (m_cnt[u] + 1) % decim_of(u);
                m_s1v[u] = m_keep;
                if (m_keep) m_s1[u] = q_pre(in_data[u]);
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            if (m_live[u]) begin
                chk("out_valid", u, longint'(out_valid[u]), longint'(m_q[u].size() > 0));
                chk("out_data", u, longint'($signed(out_data[u])),
                    (m_q[u].size() > 0) ? longint'(m_q[u][0]) : 0);
                chk("fifo_level", u, longint'(fifo_level[u]), longint'(m_q[u].size()));
                chk("overflow", u, longint'(overflow[u]), longint'(m_ovf[u]));
                chk("sat_count", u, longint'(sat_count[u]), SAT_EN ? longint'(m_sat[u]) : 0);
                if (out_valid[u] && out_ready[u]) begin
                    obs[u].push_back(int'($signed(out_data[u])));
                    obs_c[u].push_back(cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic [AW-1:0] d, input bit v);
        in_data[u]  = d;
        in_valid[u] = v;
    endtask

    task automatic pulse_reset(input int u);
        rst[u] = 1'b1;
        tick();
        rst[u] = 1'b0;
    endtask

    task automatic expect_obs(input int u, input string name, input int exp[$]);
        chk({name, "_count"}, u, obs[u].size(), exp.size());
        for (int i = 0; i < exp.size() && i < obs[u].size(); i++) begin
            chk(name, u, obs[u][i], exp[i]);
        end
        obs[u].delete();
        obs_c[u].delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp[$];
        int t0;
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b1; in_valid[u] = 1'b0; in_data[u] = '0; out_ready[u] = 1'b0;
        end
        tick(); tick();
        for (int u = 0; u < NU; u++) rst[u] = 1'b0;
        for (int u = 0; u < NU; u++) begin
            chk("reset_valid", u, longint'(out_valid[u]), 0);
            chk("reset_data", u, longint'(out_data[u]), 0);
            chk("reset_level", u, longint'(fifo_level[u]), 0);
            chk("reset_ovf", u, longint'(overflow[u]), 0);
            chk("reset_sat", u, longint'(sat_count[u]), 0);
        end

        // Rounding, back-to-back, two-cycle latency.
        out_ready[0] = 1'b1;
        t0 = cyc;
        drive(0, fx(5, 2**30), 1);      tick();
        drive(0, -fx(5, 2**30), 1);     tick();
        drive(0, fx(5, 2**30 - 1), 1);  tick();
        drive(0, '0, 0);
        repeat (4) tick();
        chk("round_latency", 0, (obs_c[0].size() > 0) ? obs_c[0][0] - t0 : -1, 2);
        exp = {6, -5, 5};
        expect_obs(0, "round", exp);

        // Saturation both ways.
        drive(0, fx(40000, 0), 1);  tick();
        drive(0, fx(-40000, 0), 1); tick();
        drive(0, '0, 0);
        repeat (4) tick();
        exp = {32767, -32768};
        expect_obs(0, "saturate", exp);
        chk("sat_count_lit", 0, longint'(sat_count[0]), SAT_EN ? 2 : 0);

        // Decimation, continuous then with gaps.
        out_ready[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(1, fx(k, 0), 1); tick();
        end
        drive(1, '0, 0);
        repeat (4) tick();
        exp = {1, 5, 9};
        expect_obs(1, "decim", exp);
        for (int k = 0; k < 12; k++) begin
            drive(1, fx(k, 0), 1); tick();
            if ($urandom_range(0, 1) == 1) begin
                drive(1, {$urandom, $urandom}, 0);
                repeat ($urandom_range(1, 3)) tick();
            end
        end
        drive(1, '0, 0);
        repeat (4) tick();
        expect_obs(1, "decim_gaps", exp);

        // Backpressure and overflow.
        pulse_reset(0);
        out_ready[0] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            drive(0, fx(k, 0), 1); tick();
        end
        drive(0, '0, 0);
        repeat (3) tick();
        chk("bp_level", 0, longint'(fifo_level[0]), 8);
        chk("bp_overflow", 0, longint'(overflow[0]), 1);
        out_ready[0] = 1'b1;
        repeat (12) tick();
        exp = {1, 2, 3, 4, 5, 6, 7, 8};
        expect_obs(0, "bp_drain", exp);
        chk("bp_valid_after", 0, longint'(out_valid[0]), 0);
        chk("bp_ovf_sticky", 0, longint'(overflow[0]), 1);

        // Reset with three buffered and one in flight.
        out_ready[0] = 1'b0;
        for (int k = 201; k <= 204; k++) begin
            drive(0, fx(k, 0), 1); tick();
        end
        drive(0, '0, 0);
        chk("mid_level_before", 0, longint'(fifo_level[0]), 3);
        pulse_reset(0);
        chk("mid_valid", 0, longint'(out_valid[0]), 0);
        chk("mid_level", 0, longint'(fifo_level[0]), 0);
        chk("mid_ovf", 0, longint'(overflow[0]), 0);
        out_ready[0] = 1'b1;
        repeat (3) tick();
        drive(0, fx(300, 0), 1); tick();
        drive(0, '0, 0);
        repeat (4) tick();
        exp = {300};
        expect_obs(0, "mid_after", exp);

        // Full FIFO with a pop coinciding with the next write.
        out_ready[0] = 1'b0;
        for (int k = 101; k <= 108; k++) begin
            drive(0, fx(k, 0), 1); tick();
        end
        drive(0, '0, 0);
        repeat (3) tick();
        chk("full_level", 0, longint'(fifo_level[0]), 8);
        drive(0, fx(109, 0), 1); tick();
        drive(0, '0, 0);
        out_ready[0] = 1'b1; tick();
        out_ready[0] = 1'b0; tick();
        chk("fullpop_level", 0, longint'(fifo_level[0]), 8);
        chk("fullpop_ovf", 0, longint'(overflow[0]), 0);
        out_ready[0] = 1'b1;
        repeat (12) tick();
        exp = {101, 102, 103, 104, 105, 106, 107, 108, 109};
        expect_obs(0, "fullpop_drain", exp);

        // Randomised traffic on both instances.
        for (int n = 0; n < 4000; n++) begin
            for (int u = 0; u < NU; u++) begin
                longint k;
                k = longint'($urandom_range(0, 100000)) - 50000;
                case ($urandom_range(0, 3))
                    0:       in_data[u] = {$urandom, $urandom};
                    1:       in_data[u] = fx(k, longint'($urandom_range(0, 32'h7FFF_FFFF)));
                    2:       in_data[u] = fx(k, 2**30);
                    default: in_data[u] = fx(k, 2**30 - 1);
                endcase
                in_valid[u]  = ($urandom_range(0, 3) != 0);
                out_ready[u] = ($urandom_range(0, 4) < 3);
                rst[u]       = ($urandom_range(0, 499) == 0);
            end
            tick();
        end
        for (int u = 0; u < NU; u++) begin
            rst[u] = 1'b0; in_valid[u] = 1'b0; out_ready[u] = 1'b1;
        end
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_out_quantizer.md
Name: fir_out_quantizer

Overview:
- Downstream stage of the pipelined FIR. It consumes the FIR's 64-bit signed accumulator output stream.
- Per kept sample: decimates by DECIM, rounds half-up, arithmetic-shifts by SHIFT, and saturates to a 16-bit signed sample.
- Results are buffered in a small first-word-fall-through FIFO with a valid/ready output handshake toward the DAC/packetiser side.
- The FIR is free-running, so there is no input backpressure. Overflow drops samples and raises a sticky flag.

Parameters:
- ACC_WIDTH, 64, input accumulator width (matches FIR DATA_OUT_WIDTH).
- OUT_WIDTH, 16, output sample width.
- SHIFT, 31, right-shift applied after rounding (0..ACC_WIDTH-1); 31 undoes Q31 tap scaling.
- DECIM, 1, decimation factor (>=1).
- PHASE, 0, kept phase within the decimation period (0..DECIM-1).
- FIFO_DEPTH, 8, output FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  single clock; all logic is posedge clk.
- reset  in  1  synchronous, active-high reset.
- in_data  in  ACC_WIDTH  signed FIR accumulator sample.
- in_valid  in  1  in_data is valid this cycle; there is no ready, so the sample is always consumed.
- out_data  out  OUT_WIDTH  signed quantised sample (FIFO head).
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer accepts out_data when out_valid is also high.
- overflow  out  1  sticky: a kept sample was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- sat_count  out  16  saturation event counter (see Optional Feature).

Behaviour:
- Reset:
  - Sampled on the clk edge while reset=1.
  - Clears the decimation counter, the S1 valid bit, and the FIFO pointers and level. out_valid=0, out_data=0, overflow=0, fifo_level=0, sat_count=0.
  - Asserting reset mid-operation flushes all in-flight and buffered samples; nothing is emitted afterwards.
- Decimation:
  - phase_cnt counts 0..DECIM-1, advances only when in_valid=1, and wraps to 0 after DECIM-1.
  - A sample is kept when in_valid=1 and phase_cnt==PHASE.
  - With DECIM=1 every valid sample is kept.
- Stage S1 (edge after a kept sample is presented):
  - rnd = sext(in_data, ACC_WIDTH+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0).
  - s1 = rnd >>> SHIFT. Arithmetic shift, so the result is round-half-toward-+inf.
  - s1_valid <= keep.
- Stage S2 / FIFO write (next edge):
  - sat = clamp(s1, -2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1).
  - Write when s1_valid=1 and (not full, or a pop happens in the same cycle).
- Latency: a kept sample presented in cycle 0 appears on out_data with out_valid=1 in cycle 2 when the FIFO was empty. Throughput is 1 sample/cycle.
- FIFO (first-word fall-through):
  - out_data is the head entry; it is held stable while out_valid=1 and out_ready=0.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave the level unchanged. This is legal when full; when empty, push and pop cannot coincide.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow:
  - If s1_valid=1, the FIFO is full and there is no pop, the sample is dropped and overflow is set.
  - overflow stays set until reset.
  - FIFO contents are unaffected by a drop.
- out_data=0 whenever out_valid=0.

Optional Feature:
- Macro: FIR_QUANT_SAT_CNT_EN.
- Defined: sat_count increments (saturating at 16'hFFFF) each time a written S2 sample was clamped. Dropped samples are not counted.
- Undefined: the counter logic is absent and sat_count is tied to 0.

Decomposition:
- Package fir_quant_pkg holds:
  - default width constants (ACC_WIDTH, OUT_WIDTH);
  - SAT_MAX/SAT_MIN localparam derivation;
  - a typedef for the signed OUT_WIDTH sample;
  - a round_shift constant for the half-LSB value.
- One sub-module, sync_fifo_fwft, provides the parameterised data width/depth FIFO. It has push/pop/full/empty/level ports, synchronous active-high reset, and no overflow logic of its own.

Test Plan:
- Rounding (DECIM=1, SHIFT=31), inputs back-to-back:
  - in_data=5*2^31+2^30 -> out_data=6.
  - in_data=-(5*2^31+2^30) -> out_data=-5.
  - in_data=5*2^31+2^30-1 -> out_data=5.
  - Each appears 2 cycles after input.
- Saturation:
  - in_data=40000*2^31 -> 32767.
  - in_data=-40000*2^31 -> -32768.
  - With FIR_QUANT_SAT_CNT_EN, sat_count=2; without the macro, sat_count=0.
- Decimation (DECIM=4, PHASE=1), in_valid=1 continuously with in_data=k*2^31 for k=0..11:
  - Outputs are 1, 5, 9.
  - Inserting in_valid=0 gaps does not change which samples are kept.
- Backpressure/overflow (FIFO_DEPTH=8), out_ready=0 while 10 kept samples 1..10 are pushed:
  - fifo_level=8, overflow=1.
  - Then out_ready=1: outputs 1..8 in order, out_valid drops, overflow stays 1.
- Full with simultaneous pop: with the FIFO full, pulse out_ready=1 in the cycle the next sample is written -> no drop, fifo_level stays 8, overflow stays 0.
- Reset mid-stream: assert reset for 1 cycle with 3 samples buffered and 1 in S1 -> next cycle out_valid=0, fifo_level=0, overflow=0, and the next output is the first sample kept after reset.
